mult_div_unit: RTL

//  HI/LO producer for the 5-stage MIPS core: runs MULT/MULTU/DIV/DIVU and MTHI/MTLO issued from E stage.

---
 rtl/mult_div_unit_pkg.sv | 23 ++
 rtl/mult_div_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared HI/LO op encodings and write-data selects
package mult_div_unit_pkg;

  // Three-bit MD op encodings; 3'd6 and 3'd7 are undefined and act as NOPs.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  // W-stage write-data selects for MFHI/MFLO.
  localparam logic WDATA_HI = 1'b1;
  localparam logic WDATA_LO = 1'b0;

  // Larger of the two op latencies, used to size the countdown.
  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MULT/DIV unit holding architectural HI/LO
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(max_cycles(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  md_op_e      op;
  logic [63:0] mul_s, mul_u;
  logic [31:0] divisor;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        div_ovf;

  assign op   = md_op_e'(md_op);
  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Result datapath: signed/unsigned products and quotients from the E-stage operands.
  always_comb begin
    mul_s   = $unsigned($signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b}));
    mul_u   = {32'b0, src_a} * {32'b0, src_b};
    // Divisor forced non-zero so the divider never sees /0; the result is discarded anyway.
    divisor = (src_b == 32'b0) ? 32'd1 : src_b;
    // The only signed overflow case is pinned explicitly rather than left to the operator.
    div_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    quo_u   = src_a / divisor;
    rem_u   = src_a % divisor;
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'b0;
    end else begin
      quo_s = $unsigned($signed(src_a) / $signed(divisor));
      rem_s = $unsigned($signed(src_a) % $signed(divisor));
    end
  end

  // Next state: cancel beats everything, then countdown/commit, then accepting a new op.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (cancel) begin
      cnt_d  = '0;
      pend_d = '0;
      dz_d   = 1'b0;
    end else if (busy) begin
      cnt_d = cnt_q - 1'b1;
      if ((cnt_q == CNT_W'(1)) && !dz_q) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end
    end else if (start) begin
      case (op)
        MD_MULT: begin
          pend_d = mul_s;
          dz_d   = 1'b0;
          cnt_d  = MULT_N;
        end
        MD_MULTU: begin
          pend_d = mul_u;
          dz_d   = 1'b0;
          cnt_d  = MULT_N;
        end
        MD_DIV: begin
          pend_d = {rem_s, quo_s};
          dz_d   = (src_b == 32'b0);
          cnt_d  = DIV_N;
        end
        MD_DIVU: begin
          pend_d = {rem_u, quo_u};
          dz_d   = (src_b == 32'b0);
          cnt_d  = DIV_N;
        end
        MD_MTHI: hi_d = src_a;
        MD_MTLO: lo_d = src_a;
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= '0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

endmodule
